// File: rtl/lcd_timing_rx_pkg.sv
// Shared definitions for the LCD timing receiver: state encoding, panel geometry, RGB565 field widths.
package lcd_timing_rx_pkg;

   typedef enum logic [1:0] {
      ST_SEARCH  = 2'd0,
      ST_MEASURE = 2'd1,
      ST_LOCKED  = 2'd2
   } rx_state_t;

   // Panel geometry, kept identical to the transmitter's
   localparam int PANEL_HTOTAL   = 525;
   localparam int PANEL_VTOTAL   = 286;
   localparam int PANEL_WIDTH    = 480;
   localparam int PANEL_HEIGHT   = 272;
   localparam int PANEL_H_OFFSET = 3;
   localparam int PANEL_V_OFFSET = 3;

   localparam int R_BITS   = 5;
   localparam int G_BITS   = 6;
   localparam int B_BITS   = 5;
   localparam int RGB_BITS = R_BITS + G_BITS + B_BITS;
   localparam int CNT_BITS = 10;

   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (v == {CNT_BITS{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/lcd_timing_rx_sync_edge_det.sv
// Registers a sync input once and flags its rising edge against the previous registered value.
module lcd_timing_rx_sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic q;
   logic q_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q   <= 1'b0;
         q_d <= 1'b0;
      end else begin
         q   <= d;
         q_d <= q;
      end
   end

   assign rise = q & ~q_d;

endmodule

// File: rtl/lcd_timing_rx.sv
// Recovers line/frame structure from Hsync/Vsync, checks it against the panel geometry and
// emits per-pixel coordinates and RGB once locked.
//
// state      | meaning
// SEARCH     | waiting for a first Vsync rise; that frame is never judged
// MEASURE    | counting consecutive good frames towards LOCK_FRAMES
// LOCKED     | geometry confirmed; pixels strobed, any mismatch returns to SEARCH
module lcd_timing_rx
   import lcd_timing_rx_pkg::*;
#(
   parameter int HTOTAL      = PANEL_HTOTAL,
   parameter int VTOTAL      = PANEL_VTOTAL,
   parameter int WIDTH       = PANEL_WIDTH,
   parameter int HEIGHT      = PANEL_HEIGHT,
   parameter int H_OFFSET    = PANEL_H_OFFSET,
   parameter int V_OFFSET    = PANEL_V_OFFSET,
   parameter int LOCK_FRAMES = 2
) (
   input  logic                CLK,
   input  logic                nRESET,
   input  logic                Hsync,
   input  logic                Vsync,
   input  logic [R_BITS-1:0]   R,
   input  logic [G_BITS-1:0]   G,
   input  logic [B_BITS-1:0]   B,
   output logic                pix_valid,
   output logic [8:0]          pix_x,
   output logic [8:0]          pix_y,
   output logic [RGB_BITS-1:0] pix_rgb,
   output logic                frame_start,
   output logic                locked,
   output logic                timing_err,
   output logic [7:0]          err_cnt
);

   rx_state_t           state;
   logic                hs_rise;
   logic                vs_rise;
   logic [RGB_BITS-1:0] rgb1;
   logic [CNT_BITS-1:0] h_cnt;
   logic [CNT_BITS-1:0] v_cnt;
   logic                line_bad;
   logic [3:0]          good_cnt;
   logic [CNT_BITS:0]   line_len;
   logic [CNT_BITS:0]   frame_len;
   logic                line_mis;
   logic                frame_good;
   logic                err_now;
   logic                h_act;
   logic                v_act;
   logic                pix_now;

   lcd_timing_rx_sync_edge_det u_hs (.clk(CLK), .rst_n(nRESET), .d(Hsync), .rise(hs_rise));
   lcd_timing_rx_sync_edge_det u_vs (.clk(CLK), .rst_n(nRESET), .d(Vsync), .rise(vs_rise));

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) rgb1 <= '0;
      else         rgb1 <= {R, G, B};
   end

   // One extra bit so a saturated counter reads as 1024 and never aliases a legal length
   assign line_len   = {1'b0, h_cnt} + 1'b1;
   assign frame_len  = {1'b0, v_cnt} + 1'b1;
   assign line_mis   = hs_rise && (line_len != (CNT_BITS+1)'(HTOTAL));
   assign frame_good = (frame_len == (CNT_BITS+1)'(VTOTAL)) && !line_bad && !line_mis;
   assign err_now    = (state == ST_LOCKED) && (line_mis || (vs_rise && !frame_good));

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         h_cnt    <= '0;
         v_cnt    <= '0;
         line_bad <= 1'b0;
      end else begin
         h_cnt <= hs_rise ? '0 : sat_inc(h_cnt);
         if (vs_rise)      v_cnt <= '0;
         else if (hs_rise) v_cnt <= sat_inc(v_cnt);
         if (vs_rise)       line_bad <= 1'b0;
         else if (line_mis) line_bad <= 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         state       <= ST_SEARCH;
         good_cnt    <= '0;
         locked      <= 1'b0;
         frame_start <= 1'b0;
         timing_err  <= 1'b0;
         err_cnt     <= '0;
      end else begin
         frame_start <= 1'b0;
         timing_err  <= 1'b0;
         case (state)
            ST_SEARCH: begin
               if (vs_rise) begin
                  state    <= ST_MEASURE;
                  good_cnt <= '0;
               end
            end
            ST_MEASURE: begin
               if (vs_rise) begin
                  if (!frame_good) begin
                     good_cnt <= '0;
                  end else if ((good_cnt + 4'd1) >= 4'(LOCK_FRAMES)) begin
                     state    <= ST_LOCKED;
                     locked   <= 1'b1;
                     good_cnt <= '0;
                  end else begin
                     good_cnt <= good_cnt + 4'd1;
                  end
               end
            end
            ST_LOCKED: begin
               if (err_now) begin
                  state      <= ST_SEARCH;
                  locked     <= 1'b0;
                  timing_err <= 1'b1;
                  if (err_cnt != 8'hff) err_cnt <= err_cnt + 8'd1;
               end else if (vs_rise) begin
                  frame_start <= 1'b1;
               end
            end
            default: begin
               state  <= ST_SEARCH;
               locked <= 1'b0;
            end
         endcase
      end
   end

   // err_now gates the strobe so pix_valid falls together with locked
   assign h_act   = (h_cnt >= CNT_BITS'(H_OFFSET)) && (h_cnt < CNT_BITS'(H_OFFSET + WIDTH));
   assign v_act   = (v_cnt >= CNT_BITS'(V_OFFSET)) && (v_cnt < CNT_BITS'(V_OFFSET + HEIGHT));
   assign pix_now = (state == ST_LOCKED) && !err_now && h_act && v_act;

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         pix_valid <= 1'b0;
         pix_x     <= '0;
         pix_y     <= '0;
         pix_rgb   <= '0;
      end else begin
         pix_valid <= pix_now;
         if (pix_now) begin
            pix_x   <= 9'(h_cnt - CNT_BITS'(H_OFFSET));
            pix_y   <= 9'(v_cnt - CNT_BITS'(V_OFFSET));
            pix_rgb <= rgb1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_timing_rx.sv
// Bench for lcd_timing_rx on a reduced panel geometry: a pin-level reference model drives a
// per-cycle scoreboard, and literal checks pin lock timing, pixel counts and error counts.
module tb_lcd_timing_rx;

   localparam int HT = 16;
   localparam int VT = 10;
   localparam int W  = 8;
   localparam int H  = 5;
   localparam int HO = 3;
   localparam int VO = 3;
   localparam int LF = 2;

   logic        CLK    = 1'b0;
   logic        nRESET = 1'b0;
   logic        Hsync  = 1'b0;
   logic        Vsync  = 1'b0;
   logic [4:0]  R      = '0;
   logic [5:0]  G      = '0;
   logic [4:0]  B      = '0;
   logic        pix_valid;
   logic [8:0]  pix_x;
   logic [8:0]  pix_y;
   logic [15:0] pix_rgb;
   logic        frame_start;
   logic        locked;
   logic        timing_err;
   logic [7:0]  err_cnt;

   lcd_timing_rx #(
      .HTOTAL(HT), .VTOTAL(VT), .WIDTH(W), .HEIGHT(H),
      .H_OFFSET(HO), .V_OFFSET(VO), .LOCK_FRAMES(LF)
   ) dut (
      .CLK(CLK), .nRESET(nRESET), .Hsync(Hsync), .Vsync(Vsync),
      .R(R), .G(G), .B(B),
      .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
      .frame_start(frame_start), .locked(locked), .timing_err(timing_err), .err_cnt(err_cnt)
   );

   always #40 CLK = ~CLK;

   typedef struct packed {
      logic        valid;
      logic [8:0]  x;
      logic [8:0]  y;
      logic [15:0] rgb;
      logic        fs;
      logic        lk;
      logic        te;
      logic [7:0]  ec;
   } exp_t;

   exp_t        expq[$];
   exp_t        cur;
   int          vectors = 0;
   int          miscompares = 0;

   // Reference model: pin-cycle index and the positions of recent sync edges
   longint      p = 0;
   longint      last_hs = 0;
   longint      hs_since_vs = 0;
   bit          hs_prev, vs_prev, m_frame_bad, m_locked, m_armed;
   int          m_good, m_errs;
   logic [8:0]  hold_x, hold_y;
   logic [15:0] hold_rgb;

   int          cnt_valid, cnt_fs, cnt_te;
   logic [8:0]  first_x, first_y, last_x, last_y;

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
      end
   endfunction

   function automatic void model_reset();
      hs_prev = 0; vs_prev = 0;
      last_hs = p - 5000;
      hs_since_vs = 0;
      m_frame_bad = 0; m_locked = 0; m_armed = 0;
      m_good = 0; m_errs = 0;
      hold_x = '0; hold_y = '0; hold_rgb = '0;
      expq.delete();
   endfunction

   // Expected outputs for the pixel presented on the pins this cycle (visible 2 clocks later)
   function automatic void model_step(input bit hs, input bit vs, input logic [15:0] rgb);
      bit     hs_e, vs_e, lmis, fgood, err;
      longint h, v;
      exp_t   e;
      hs_e  = hs && !hs_prev;
      vs_e  = vs && !vs_prev;
      h     = p - last_hs - 1;
      if (h > 1023) h = 1023;
      v     = (hs_since_vs > 1023) ? 1023 : hs_since_vs;
      lmis  = hs_e && (h + 1 != HT);
      fgood = (v + 1 == VT) && !m_frame_bad && !lmis;
      err   = m_locked && (lmis || (vs_e && !fgood));
      e     = '0;
      e.valid = m_locked && !err && (h >= HO) && (h < HO + W) && (v >= VO) && (v < VO + H);
      if (e.valid) begin
         hold_x   = 9'(h - HO);
         hold_y   = 9'(v - VO);
         hold_rgb = rgb;
      end
      e.fs = m_locked && vs_e && !err;
      e.te = err;
      if (err) begin
         m_locked = 0;
         m_armed  = 0;
         if (m_errs < 255) m_errs++;
      end else if (vs_e && !m_locked) begin
         if (!m_armed) begin
            m_armed = 1;
            m_good  = 0;
         end else if (fgood) begin
            m_good++;
            if (m_good >= LF) m_locked = 1;
         end else begin
            m_good = 0;
         end
      end
      e.lk  = m_locked;
      e.ec  = 8'(m_errs);
      e.x   = hold_x;
      e.y   = hold_y;
      e.rgb = hold_rgb;
      if (vs_e)      m_frame_bad = 0;
      else if (lmis) m_frame_bad = 1;
      if (hs_e) last_hs = p;
      if (vs_e)      hs_since_vs = 0;
      else if (hs_e) hs_since_vs++;
      hs_prev = hs;
      vs_prev = vs;
      expq.push_back(e);
   endfunction

   always @(negedge CLK) begin
      if (nRESET && expq.size() >= 3) begin
         cur = expq.pop_front();
         check("pix_valid",   32'(pix_valid),   32'(cur.valid));
         check("pix_x",       32'(pix_x),       32'(cur.x));
         check("pix_y",       32'(pix_y),       32'(cur.y));
         check("pix_rgb",     32'(pix_rgb),     32'(cur.rgb));
         check("frame_start", 32'(frame_start), 32'(cur.fs));
         check("locked",      32'(locked),      32'(cur.lk));
         check("timing_err",  32'(timing_err),  32'(cur.te));
         check("err_cnt",     32'(err_cnt),     32'(cur.ec));
      end
   end

   always @(negedge CLK) begin
      if (nRESET) begin
         if (pix_valid) begin
            if (cnt_valid == 0) begin
               first_x = pix_x;
               first_y = pix_y;
            end
            last_x = pix_x;
            last_y = pix_y;
            cnt_valid++;
         end
         if (frame_start) cnt_fs++;
         if (timing_err)  cnt_te++;
      end
   end

   task automatic clr_cnt();
      cnt_valid = 0; cnt_fs = 0; cnt_te = 0;
      first_x = '0; first_y = '0; last_x = '0; last_y = '0;
   endtask

   task automatic cyc(input bit hs, input bit vs);
      logic [15:0] rgb;
      @(posedge CLK);
      #1;
      rgb   = 16'(p * 37 + 5);
      Hsync = hs;
      Vsync = vs;
      {R, G, B} = rgb;
      model_step(hs, vs, rgb);
      p++;
   endtask

   task automatic line(input int len, input bit vs_line);
      for (int i = 0; i < len; i++) cyc(i < 2, vs_line);
   endtask

   // Vsync is high for the first two lines, so its rise coincides with an Hsync rise
   task automatic frame(input int nlines, input int short_idx);
      for (int l = 0; l < nlines; l++) line((l == short_idx) ? HT - 1 : HT, l < 2);
   endtask

   task automatic check_count(input string name, input int act, input int exp_v);
      check(name, 32'(act), 32'(exp_v));
   endtask

   initial begin
      model_reset();
      clr_cnt();
      repeat (3) @(posedge CLK);
      #1;
      check("rst_pix_valid",   32'(pix_valid),   0);
      check("rst_pix_x",       32'(pix_x),       0);
      check("rst_pix_y",       32'(pix_y),       0);
      check("rst_pix_rgb",     32'(pix_rgb),     0);
      check("rst_frame_start", 32'(frame_start), 0);
      check("rst_locked",      32'(locked),      0);
      check("rst_timing_err",  32'(timing_err),  0);
      check("rst_err_cnt",     32'(err_cnt),     0);
      @(negedge CLK) nRESET = 1'b1;

      // Nominal stream: lock is declared at the third Vsync rise
      frame(VT, -1);
      frame(VT, -1);
      check("unlocked_after_2_vs", 32'(locked), 0);
      clr_cnt();
      frame(VT, -1);
      check("locked_at_3rd_vs", 32'(locked), 1);
      check_count("valid_per_frame_a", cnt_valid, W * H);
      check("first_x", 32'(first_x), 0);
      check("first_y", 32'(first_y), 0);
      check("last_x",  32'(last_x),  W - 1);
      check("last_y",  32'(last_y),  H - 1);
      check_count("no_fs_on_lock_frame", cnt_fs, 0);
      clr_cnt();
      frame(VT, -1);
      check_count("fs_per_frame", cnt_fs, 1);
      check_count("valid_per_frame_b", cnt_valid, W * H);
      check_count("no_err_nominal", cnt_te, 0);

      // One short line while locked
      clr_cnt();
      frame(VT, 5);
      check_count("short_line_err_pulses", cnt_te, 1);
      check("short_line_err_cnt", 32'(err_cnt), 1);
      check("short_line_unlocked", 32'(locked), 0);
      clr_cnt();
      frame(VT, -1);
      frame(VT, -1);
      check("relock_not_yet", 32'(locked), 0);
      frame(VT, -1);
      check("relock_after_2_good", 32'(locked), 1);
      check_count("relock_no_err", cnt_te, 0);

      // Short frame while locked, then a short frame while measuring
      clr_cnt();
      frame(VT - 1, -1);
      frame(VT, -1);
      check_count("short_frame_err_pulses", cnt_te, 1);
      check("short_frame_err_cnt", 32'(err_cnt), 2);
      check("short_frame_unlocked", 32'(locked), 0);
      frame(VT, -1);
      frame(VT - 1, -1);
      frame(VT, -1);
      check("measure_bad_resets_count", 32'(locked), 0);
      frame(VT, -1);
      check("measure_one_good", 32'(locked), 0);
      frame(VT, -1);
      check("measure_relock", 32'(locked), 1);

      // Asynchronous reset mid-frame while locked
      for (int l = 0; l < 5; l++) line(HT, l < 2);
      check("pre_reset_locked",  32'(locked),  1);
      check("pre_reset_err_cnt", 32'(err_cnt), 2);
      #20 nRESET = 1'b0;
      #1;
      check("async_rst_pix_valid", 32'(pix_valid), 0);
      check("async_rst_locked",    32'(locked),    0);
      check("async_rst_err_cnt",   32'(err_cnt),   0);
      check("async_rst_pix_rgb",   32'(pix_rgb),   0);
      check("async_rst_pix_x",     32'(pix_x),     0);
      model_reset();
      Hsync = 1'b0;
      Vsync = 1'b0;
      {R, G, B} = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK) nRESET = 1'b1;
      frame(VT, -1);
      frame(VT, -1);
      check("post_reset_unlocked", 32'(locked), 0);
      frame(VT, -1);
      check("post_reset_relock", 32'(locked), 1);
      check("post_reset_err_cnt", 32'(err_cnt), 0);
      frame(VT, -1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
